// File: rtl/mxm_seq_ctrl.sv
// Loop/address sequencer for the 8x8 matrix-multiply datapath: operand reads, MAC strobes, result writes.
// Optional build macro MXM_SEQ_PAUSE_EN adds a pause input that stalls read issue during a run.
module mxm_seq_ctrl #(
    parameter int N      = 8,
    parameter int AW     = 6,
    parameter int RD_LAT = 1,
    parameter int CW     = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
`ifdef MXM_SEQ_PAUSE_EN
    input  logic          pause,
`endif
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] clock_count,
    output logic          rd_en,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic          mac_en,
    output logic          mac_clr,
    output logic          c_we,
    output logic [AW-1:0] c_addr
);
    localparam int LW = $clog2(N);
    localparam logic [LW-1:0] L_ZERO = {LW{1'b0}};
    localparam logic [LW-1:0] L_ONE  = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] L_MAX  = {LW{1'b1}};
    localparam logic [CW-1:0] C_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] C_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] C_MAX  = {CW{1'b1}};
    localparam logic [AW-1:0] A_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] A_MAX  = {AW{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t        state_r;
    logic [LW-1:0] i_r, j_r, k_r;
    logic          start_q_r;
    logic          busy_r;
    logic          done_r;
    logic [CW-1:0] count_r;
    logic [AW-1:0] a_addr_r, b_addr_r;
    logic          c_we_r;
    logic [AW-1:0] c_addr_r;

    // Stage 0 is the read-issue register itself; stage RD_LAT lines up with RAM data.
    logic          pipe_v_r [0:RD_LAT];
    logic          pipe_f_r [0:RD_LAT];
    logic          pipe_l_r [0:RD_LAT];
    logic [AW-1:0] pipe_a_r [0:RD_LAT];

    logic pause_s;
    logic start_acc_s;
    logic issue_s;
    logic last_rd_s;
    logic wr_s;
    logic fin_wr_s;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v == C_MAX) begin
            return v;
        end else begin
            return v + C_ONE;
        end
    endfunction

`ifdef MXM_SEQ_PAUSE_EN
    assign pause_s = pause;
`else
    assign pause_s = 1'b0;
`endif

    // A run starts only on a fresh rising START seen in IDLE, never in the DONE cycle.
    assign start_acc_s = (state_r == IDLE) && start && !start_q_r && !done_r;
    assign issue_s     = (state_r == ISSUE) && !pause_s;
    assign last_rd_s   = (i_r == L_MAX) && (j_r == L_MAX) && (k_r == L_MAX);
    assign wr_s        = pipe_v_r[RD_LAT] && pipe_l_r[RD_LAT];
    assign fin_wr_s    = wr_s && (pipe_a_r[RD_LAT] == A_MAX);

    // Sequencer FSM: loop counters, read addresses, status flags and run-time counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            i_r       <= L_ZERO;
            j_r       <= L_ZERO;
            k_r       <= L_ZERO;
            start_q_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            count_r   <= C_ZERO;
            a_addr_r  <= A_ZERO;
            b_addr_r  <= A_ZERO;
        end else begin
            start_q_r <= start;
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start_acc_s) begin
                        state_r <= ISSUE;
                        count_r <= C_ZERO;
                        i_r     <= L_ZERO;
                        j_r     <= L_ZERO;
                        k_r     <= L_ZERO;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    busy_r  <= 1'b1;
                    count_r <= sat_inc(count_r);
                    if (issue_s) begin
                        a_addr_r <= {k_r, j_r};
                        b_addr_r <= {i_r, k_r};
                        k_r      <= k_r + L_ONE;
                        if (k_r == L_MAX) begin
                            j_r <= j_r + L_ONE;
                            if (j_r == L_MAX) begin
                                i_r <= i_r + L_ONE;
                            end else begin
                                i_r <= i_r;
                            end
                        end else begin
                            j_r <= j_r;
                        end
                        if (last_rd_s) begin
                            state_r <= DRAIN;
                        end else begin
                            state_r <= ISSUE;
                        end
                    end else begin
                        a_addr_r <= A_ZERO;
                        b_addr_r <= A_ZERO;
                    end
                end
                DRAIN: begin
                    busy_r   <= 1'b1;
                    count_r  <= sat_inc(count_r);
                    a_addr_r <= A_ZERO;
                    b_addr_r <= A_ZERO;
                    if (fin_wr_s) begin
                        state_r <= FIN;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                FIN: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Read-to-MAC delay line carrying element tags, plus the output-write register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s <= RD_LAT; s++) begin
                pipe_v_r[s] <= 1'b0;
                pipe_f_r[s] <= 1'b0;
                pipe_l_r[s] <= 1'b0;
                pipe_a_r[s] <= A_ZERO;
            end
            c_we_r   <= 1'b0;
            c_addr_r <= A_ZERO;
        end else begin
            pipe_v_r[0] <= issue_s;
            pipe_f_r[0] <= issue_s && (k_r == L_ZERO);
            pipe_l_r[0] <= issue_s && (k_r == L_MAX);
            pipe_a_r[0] <= {i_r, j_r};
            for (int s = 1; s <= RD_LAT; s++) begin
                pipe_v_r[s] <= pipe_v_r[s-1];
                pipe_f_r[s] <= pipe_f_r[s-1];
                pipe_l_r[s] <= pipe_l_r[s-1];
                pipe_a_r[s] <= pipe_a_r[s-1];
            end
            c_we_r <= wr_s;
            if (wr_s) begin
                c_addr_r <= pipe_a_r[RD_LAT];
            end else begin
                c_addr_r <= c_addr_r;
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign clock_count = count_r;
    assign rd_en       = pipe_v_r[0];
    assign a_addr      = a_addr_r;
    assign b_addr      = b_addr_r;
    assign mac_en      = pipe_v_r[RD_LAT];
    assign mac_clr     = pipe_f_r[RD_LAT];
    assign c_we        = c_we_r;
    assign c_addr      = c_addr_r;

endmodule

// File: tb/tb_mxm_seq_ctrl.sv
// Directed bench for mxm_seq_ctrl: a behavioural RAM/MAC datapath around the sequencer
// checks results, strobe counts, address order and run timing.
module tb_mxm_seq_ctrl;
    localparam int N      = 8;
    localparam int AW     = 6;
    localparam int RD_LAT = 1;
    localparam int CW     = 11;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
`ifdef MXM_SEQ_PAUSE_EN
    logic          pause = 1'b0;
    int            pause_from = -1000;
`endif
    logic          busy, done, rd_en, mac_en, mac_clr, c_we;
    logic [CW-1:0] clock_count;
    logic [AW-1:0] a_addr, b_addr, c_addr;

    mxm_seq_ctrl #(.N(N), .AW(AW), .RD_LAT(RD_LAT), .CW(CW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
`ifdef MXM_SEQ_PAUSE_EN
        .pause(pause),
`endif
        .busy(busy),
        .done(done),
        .clock_count(clock_count),
        .rd_en(rd_en),
        .a_addr(a_addr),
        .b_addr(b_addr),
        .mac_en(mac_en),
        .mac_clr(mac_clr),
        .c_we(c_we),
        .c_addr(c_addr)
    );

    always #5 clk = ~clk;

    // Datapath model: 1-cycle operand RAMs, signed MAC, result RAM
    logic signed [7:0]  mem_a [0:63];
    logic signed [7:0]  mem_b [0:63];
    logic signed [31:0] mem_c [0:63];
    logic signed [31:0] exp_c [0:63];
    logic signed [7:0]  a_q = 8'sd0;
    logic signed [7:0]  b_q = 8'sd0;
    logic signed [31:0] acc = 32'sd0;
    logic signed [31:0] prod;
    assign prod = 32'(a_q) * 32'(b_q);

    always @(posedge clk) begin
        if (rd_en) begin
            a_q <= mem_a[a_addr];
            b_q <= mem_b[b_addr];
        end
        if (mac_en) acc <= mac_clr ? prod : acc + prod;
        if (c_we) mem_c[c_addr] <= acc;
    end

    int ecount = 0;
    int t0 = 0;
    always @(posedge clk) ecount <= ecount + 1;

    int checks = 0;
    int errors = 0;
    int mon_cy;
    int we_cnt, exp_caddr, order_err, mac_en_cnt, clr_cnt, clr_err, done_cnt, done_cyc, last_we_cyc;
    int a_log [0:15];
    int b_log [0:15];

    // Event monitor, sampled on the falling edge; cycle 0 is the START-sampling edge
    always @(negedge clk) begin
        mon_cy = ecount - t0;
        if (rd_en && mon_cy >= 0 && mon_cy < 16) begin
            a_log[mon_cy] = int'(a_addr);
            b_log[mon_cy] = int'(b_addr);
        end
        if (c_we) begin
            if (int'(c_addr) != exp_caddr) order_err++;
            exp_caddr++;
            we_cnt++;
            last_we_cyc = mon_cy;
        end
        if (mac_en) begin
            if (mac_clr !== ((mac_en_cnt % 8) == 0)) clr_err++;
            if (mac_clr) clr_cnt++;
            mac_en_cnt++;
        end else if (mac_clr) begin
            clr_err++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = mon_cy;
        end
    end

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic clear_stats();
        we_cnt = 0; exp_caddr = 0; order_err = 0; mac_en_cnt = 0; clr_cnt = 0;
        clr_err = 0; done_cnt = 0; done_cyc = -1; last_we_cyc = -1;
        for (int n = 0; n < 16; n++) begin
            a_log[n] = -1;
            b_log[n] = -1;
        end
        for (int n = 0; n < 64; n++) mem_c[n] = 32'sd99999;
    endtask

    task automatic start_run(input int hold);
        @(negedge clk);
        clear_stats();
        start = 1'b1;
        @(posedge clk);
        #1;
        t0 = ecount;
        repeat (hold - 1) @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Bounded wait for DONE; optionally re-pulses START so it is sampled at edge repulse+1
    task automatic wait_done(input int repulse);
        int cy;
        for (int n = 0; n < 800 && done_cnt == 0; n++) begin
            @(negedge clk);
            cy = ecount - t0;
            start = (cy == repulse);
`ifdef MXM_SEQ_PAUSE_EN
            pause = (cy >= pause_from - 1) && (cy < pause_from + 9);
`endif
        end
        start = 1'b0;
`ifdef MXM_SEQ_PAUSE_EN
        pause = 1'b0;
`endif
        repeat (3) @(negedge clk);
    endtask

    task automatic check_c(input string tag);
        int m;
        m = 0;
        for (int n = 0; n < 64; n++) if (mem_c[n] !== exp_c[n]) m++;
        check(tag, m, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_count"}, clock_count, 0);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_a_addr"}, a_addr, 0);
        check({tag, "_b_addr"}, b_addr, 0);
        check({tag, "_mac_en"}, mac_en, 0);
        check({tag, "_mac_clr"}, mac_clr, 0);
        check({tag, "_c_we"}, c_we, 0);
        check({tag, "_c_addr"}, c_addr, 0);
    endtask

    initial begin
        clear_stats();
        // Reset for two cycles
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("rst");
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Identity x identity
        for (int n = 0; n < 64; n++) begin
            mem_a[n] = (n % 9 == 0) ? 8'sd1 : 8'sd0;
            mem_b[n] = (n % 9 == 0) ? 8'sd1 : 8'sd0;
            exp_c[n] = (n % 9 == 0) ? 32'sd1 : 32'sd0;
        end
        start_run(1);
        wait_done(-1);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_done_cyc", done_cyc, 515);
        check("t1_count", clock_count, 514);
        check("t1_we_cnt", we_cnt, 64);
        check("t1_addr_order", order_err, 0);
        check("t1_last_we_cyc", last_we_cyc, 514);
        check("t1_mac_en_cnt", mac_en_cnt, 512);
        check("t1_busy_after", busy, 0);
        check_c("t1_c_identity");
        // First read addresses
        check("t3_a1", a_log[1], 0);
        check("t3_a2", a_log[2], 8);
        check("t3_a3", a_log[3], 16);
        check("t3_b1", b_log[1], 0);
        check("t3_b2", b_log[2], 1);
        check("t3_b3", b_log[3], 2);
        check("t3_a9", a_log[9], 1);
        check("t3_b9", b_log[9], 0);

        // Extreme operands: 127 * -128 * 8
        for (int n = 0; n < 64; n++) begin
            mem_a[n] = 8'sd127;
            mem_b[n] = -8'sd128;
            exp_c[n] = -32'sd130048;
        end
        start_run(1);
        wait_done(-1);
        check_c("t2_c_extreme");
        check("t2_c37", mem_c[37], -130048);
        check("t2_clr_cnt", clr_cnt, 64);
        check("t2_clr_spacing", clr_err, 0);
        check("t2_we_cnt", we_cnt, 64);

        // START re-pulsed mid-run is ignored
        start_run(1);
        wait_done(99);
        repeat (20) @(negedge clk);
        check("t4_done_cnt", done_cnt, 1);
        check("t4_done_cyc", done_cyc, 515);
        check("t4_count", clock_count, 514);
        // START held for three cycles gives a single run
        start_run(3);
        wait_done(-1);
        repeat (600) @(negedge clk);
        check("t4_hold_done_cnt", done_cnt, 1);
        check("t4_hold_we_cnt", we_cnt, 64);

        // Async reset mid-run, then a fresh run with C = B
        for (int n = 0; n < 64; n++) begin
            mem_a[n] = (n % 9 == 0) ? 8'sd1 : 8'sd0;
            mem_b[n] = 8'(n - 32);
            exp_c[n] = n - 32;
        end
        start_run(1);
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (ecount - t0 >= 200) break;
        end
        check("t5_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1 check_reset_outputs("t5_async");
        repeat (3) @(negedge clk);
        check("t5_no_done", done_cnt, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        start_run(1);
        wait_done(-1);
        check("t5_done_cyc", done_cyc, 515);
        check("t5_count", clock_count, 514);
        check_c("t5_c_equals_b");

`ifdef MXM_SEQ_PAUSE_EN
        // Pause for ten cycles from cycle 50
        pause_from = 50;
        start_run(1);
        wait_done(-1);
        pause_from = -1000;
        check("t6_done_cyc", done_cyc, 525);
        check("t6_count", clock_count, 524);
        check("t6_we_cnt", we_cnt, 64);
        check("t6_addr_order", order_err, 0);
        check_c("t6_c_pause");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
